// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side bundle between the UART receive FIFO and the
// host communication interface.
//   rd_en       host -> fifo : pop the FIFO head this cycle
//   rx_data     fifo -> host : FIFO head (first-word fall-through)
//   rx_empty    fifo -> host : FIFO holds no bytes
//   rx_full     fifo -> host : FIFO holds 2^FIFO_ADDR_BITS bytes
//   parity_err  fifo -> host : one-cycle pulse, committed byte had bad parity
//   frame_err   fifo -> host : one-cycle pulse, stop bit sampled low
//   overrun     fifo -> host : one-cycle pulse, byte dropped on a full FIFO
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 rd_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 rx_full;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    // Host side: consumes bytes and status.
    modport master (
        output rd_en,
        input  rx_data, rx_empty, rx_full, parity_err, frame_err, overrun
    );

    // Receiver side: produces bytes and status.
    modport slave (
        input  rd_en,
        output rx_data, rx_empty, rx_full, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive half of the host serial link. Oversamples rx at 16x
// the bit rate, deframes start/data/parity/stop, checks parity and pushes
// received bytes into a first-word-fall-through FIFO.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   rx    serial input, idle high, asynchronous to clk
//   host  read-side bundle (uart_rx_fifo_if.slave): rd_en in; rx_data,
//         rx_empty, rx_full, parity_err, frame_err, overrun out
module uart_rx_fifo #(
    parameter int SYS_CLK_FREQ   = 100000000,
    parameter int BAUD_RATE      = 38400,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_MODE    = 1,
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_fifo_if.slave  host
);

    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TCNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int DEPTH   = 1 << FIFO_ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    // Parity check of a received byte plus its parity bit.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                        input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY_MODE == 1)      return ~x;
        else if (PARITY_MODE == 2) return x;
        else                       return 1'b0;
    endfunction

    state_t                state, state_nxt;
    logic                  rx_meta, rx_sync;
    logic [TCNT_W-1:0]     tick_cnt;
    logic                  tick;
    logic [3:0]            samp_cnt;
    logic                  mid;
    logic [IDX_W-1:0]      bit_idx;
    logic                  last_data, last_stop;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  par_bad;
    logic                  start_entry, shift_en, par_en, stop_en;
    logic                  commit_set, frame_set;
    logic                  commit_p0, par_bad_p0, frame_err_p0;
    logic [DATA_BITS-1:0]  byte_p0;
    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [FIFO_ADDR_BITS:0] wr_ptr, rd_ptr;
    logic                  fifo_empty, fifo_full, do_pop, do_push;

    // ---- input synchroniser (idle level on reset) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ---- 16x oversampling tick; realigned to the start edge ----
    assign tick = (tick_cnt == TCNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      tick_cnt <= '0;
        else if (start_entry || tick) tick_cnt <= '0;
        else                          tick_cnt <= tick_cnt + 1'b1;
    end

    // Start bit is sampled after 8 ticks (mid-bit), every later bit 16 ticks on.
    assign mid       = tick && (samp_cnt == ((state == S_START) ? 4'd7 : 4'd15));
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));

    // ---- deframing FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---- deframing FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (tick && !rx_sync) state_nxt = S_START;
            S_START:  if (mid) state_nxt = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (mid && last_data)
                          state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (mid) state_nxt = S_STOP;
            S_STOP:   if (mid) begin
                          if (!rx_sync)      state_nxt = S_BREAK;
                          else if (last_stop) state_nxt = S_IDLE;
                      end
            S_BREAK:  if (tick && rx_sync) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---- deframing FSM: strobes ----
    always_comb begin
        start_entry = 1'b0;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        stop_en     = 1'b0;
        commit_set  = 1'b0;
        frame_set   = 1'b0;
        case (state)
            S_IDLE:   start_entry = tick && !rx_sync;
            S_DATA:   shift_en    = mid;
            S_PARITY: par_en      = mid;
            S_STOP: begin
                stop_en    = mid;
                commit_set = mid && rx_sync && last_stop;
                frame_set  = mid && !rx_sync;
            end
            default: ;
        endcase
    end

    // ---- sample / bit counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt <= '0;
            bit_idx  <= '0;
            par_bad  <= 1'b0;
        end else begin
            if (start_entry)
                samp_cnt <= '0;
            else if (tick && state != S_IDLE && state != S_BREAK)
                samp_cnt <= mid ? 4'd0 : samp_cnt + 4'd1;

            // bit_idx counts data bits, then is reused to count stop bits.
            if (start_entry)   bit_idx <= '0;
            else if (shift_en) bit_idx <= last_data ? '0 : bit_idx + 1'b1;
            else if (stop_en)  bit_idx <= bit_idx + 1'b1;

            if (start_entry) par_bad <= 1'b0;
            else if (par_en) par_bad <= parity_bad(shift_reg, rx_sync);
        end
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (shift_en) shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
    end

    // ---- commit stage: byte handed to the FIFO one cycle after the stop sample ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_p0    <= 1'b0;
            par_bad_p0   <= 1'b0;
            frame_err_p0 <= 1'b0;
        end else begin
            commit_p0    <= commit_set;
            par_bad_p0   <= commit_set && par_bad;
            frame_err_p0 <= frame_set;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_set) byte_p0 <= shift_reg;
    end

    // ---- FIFO ----
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_ADDR_BITS-1:0] == rd_ptr[FIFO_ADDR_BITS-1:0]) &&
                        (wr_ptr[FIFO_ADDR_BITS] != rd_ptr[FIFO_ADDR_BITS]);
    assign do_pop     = host.rd_en && !fifo_empty;
    // A pop in the same cycle frees the slot the full-FIFO push lands in.
    assign do_push    = commit_p0 && (!fifo_full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_ADDR_BITS-1:0]] <= byte_p0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Memory is not reset, so the head is forced to zero while empty.
    assign host.rx_data    = fifo_empty ? '0 : mem[rd_ptr[FIFO_ADDR_BITS-1:0]];
    assign host.rx_empty   = fifo_empty;
    assign host.rx_full    = fifo_full;
    assign host.parity_err = commit_p0 && par_bad_p0;
    assign host.frame_err  = frame_err_p0;
    assign host.overrun    = commit_p0 && fifo_full && !do_pop;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into uart_rx_fifo and checks the read
// side every cycle against a queue-based reference model. The commit cycle of
// each frame is computed from the frame start time: 2 synchroniser flops plus
// one detect cycle, half a bit to mid-start, then one bit time per data,
// parity and stop bit.
module tb_uart_rx_fifo;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int PARITY_MODE = 1;
    localparam int FIFO_ADDR_BITS = 3;
    localparam int DEPTH = 8;
    localparam int BIT_CLK = 16;
    localparam int LAT = 3 + BIT_CLK/2 + BIT_CLK*(DATA_BITS + 1 + STOP_BITS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic rd_en = 1'b0;

    uart_rx_fifo_if #(.DATA_BITS(DATA_BITS)) host();
    assign host.rd_en = rd_en;

    uart_rx_fifo #(
        .SYS_CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS), .PARITY_MODE(PARITY_MODE),
        .FIFO_ADDR_BITS(FIFO_ADDR_BITS)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .host(host)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected events, written by the stimulus process only.
    int          sc_cyc   [0:127];
    logic [7:0]  sc_byte  [0:127];
    bit          sc_frame [0:127];
    bit          sc_pbad  [0:127];
    int          n_sc = 0;

    // Read request controls, written by the stimulus process only.
    int rd_issued = 0;
    int rd_at = -1;
    bit rd_rand = 1'b0;

    // Pulse counters, written by the compare process only.
    int pe_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    // rd_en driver
    initial begin
        int rd_done;
        rd_done = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rd_issued != rd_done) begin
                rd_en = 1'b1;
                rd_done++;
            end else if (cyc == rd_at)
                rd_en = 1'b1;
            else if (rd_rand)
                rd_en = ($urandom_range(0, 3) == 0);
            else
                rd_en = 1'b0;
        end
    end

    // Reference model and per-cycle compare
    initial begin
        logic [7:0] q[$];
        int si;
        bit has_commit, exp_pe, exp_fe, exp_ov, pop;
        logic [7:0] cb;
        si = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                si = n_sc;
            end else begin
                check("rx_empty", 32'(host.rx_empty), 32'(q.size() == 0));
                check("rx_full", 32'(host.rx_full), 32'(q.size() == DEPTH));
                if (q.size() != 0) check("rx_data", 32'(host.rx_data), 32'(q[0]));
                has_commit = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0; cb = 8'h00;
                while (si < n_sc && sc_cyc[si] < cyc) si++;
                if (si < n_sc && sc_cyc[si] == cyc) begin
                    if (sc_frame[si]) exp_fe = 1'b1;
                    else begin
                        has_commit = 1'b1;
                        cb = sc_byte[si];
                        exp_pe = sc_pbad[si];
                    end
                    si++;
                end
                pop = rd_en && (q.size() != 0);
                exp_ov = has_commit && (q.size() == DEPTH) && !pop;
                check("parity_err", 32'(host.parity_err), 32'(exp_pe));
                check("frame_err", 32'(host.frame_err), 32'(exp_fe));
                check("overrun", 32'(host.overrun), 32'(exp_ov));
                if (host.parity_err) pe_cnt++;
                if (host.frame_err) fe_cnt++;
                if (host.overrun) ov_cnt++;
                if (pop) void'(q.pop_front());
                if (has_commit && !exp_ov) q.push_back(cb);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(BIT_CLK);
    endtask

    task automatic send(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic p;
        p = ~(^b);
        if (!par_ok) p = ~p;
        sc_cyc[n_sc] = cyc + LAT;
        sc_byte[n_sc] = b;
        sc_frame[n_sc] = !stop_ok;
        sc_pbad[n_sc] = !par_ok;
        n_sc++;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(stop_ok);
        if (!stop_ok) begin
            idle(8);
            rx = 1'b1;
            idle(6);
        end
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        idle(len);
        rx = 1'b1;
        idle(BIT_CLK);
    endtask

    task automatic check_reset_outputs();
        check("rst_empty", 32'(host.rx_empty), 32'd1);
        check("rst_full", 32'(host.rx_full), 32'd0);
        check("rst_data", 32'(host.rx_data), 32'd0);
        check("rst_pe", 32'(host.parity_err), 32'd0);
        check("rst_fe", 32'(host.frame_err), 32'd0);
        check("rst_ov", 32'(host.overrun), 32'd0);
    endtask

    initial begin
        int pe0, fe0, ov0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(20);

        // Single good byte, then one read
        pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        send(8'hA5, 1'b1, 1'b1);
        check("a5_data", 32'(host.rx_data), 32'hA5);
        check("a5_empty", 32'(host.rx_empty), 32'd0);
        rd_issued++;
        idle(2);
        check("a5_read_empty", 32'(host.rx_empty), 32'd1);
        check("a5_no_pulses", 32'(pe_cnt + fe_cnt + ov_cnt), 32'(pe0 + fe0 + ov0));

        // Wrong parity is still stored, one parity_err cycle
        pe0 = pe_cnt;
        send(8'h3C, 1'b0, 1'b1);
        check("3c_data", 32'(host.rx_data), 32'h3C);
        check("3c_pe_cycles", 32'(pe_cnt - pe0), 32'd1);
        rd_issued++;
        idle(2);

        // Glitch, framing error, then recovery
        fe0 = fe_cnt;
        glitch(4);
        check("glitch_empty", 32'(host.rx_empty), 32'd1);
        send(8'h00, 1'b1, 1'b0);
        check("fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("fe_empty", 32'(host.rx_empty), 32'd1);
        send(8'h11, 1'b1, 1'b1);
        check("after_fe_data", 32'(host.rx_data), 32'h11);
        rd_issued++;
        idle(2);

        // Fill past capacity with no reads
        ov0 = ov_cnt;
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 1'b1, 1'b1);
            if (i == 8) check("full_after_8", 32'(host.rx_full), 32'd1);
        end
        check("overrun_9th", 32'(ov_cnt - ov0), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", 32'(host.rx_data), 32'(i));
            rd_issued++;
            idle(1);
        end
        check("drain_empty", 32'(host.rx_empty), 32'd1);

        // Full FIFO with a read on the commit cycle
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 1'b1, 1'b1);
        check("refill_full", 32'(host.rx_full), 32'd1);
        ov0 = ov_cnt;
        rd_at = cyc + LAT;
        send(8'h55, 1'b1, 1'b1);
        check("pushpop_no_ov", 32'(ov_cnt - ov0), 32'd0);
        check("pushpop_full", 32'(host.rx_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("pushpop_order", 32'(host.rx_data), (i < 7) ? 32'(8'h61 + 8'(i)) : 32'h55);
            rd_issued++;
            idle(1);
        end

        // Asynchronous reset in the middle of a frame
        send(8'h77, 1'b1, 1'b1);
        rx = 1'b0;
        idle(BIT_CLK);
        rx = 1'b1;
        idle(30);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        idle(200);
        check("post_reset_empty", 32'(host.rx_empty), 32'd1);

        // Randomized traffic with random reads
        rd_rand = 1'b1;
        repeat (25) begin
            case ($urandom_range(0, 9))
                0: glitch($urandom_range(1, 6));
                1: send(8'($urandom), 1'b1, 1'b0);
                default: send(8'($urandom), $urandom_range(0, 4) != 0, 1'b1);
            endcase
            idle($urandom_range(0, 12));
        end
        rd_rand = 1'b0;
        idle(2);
        rd_issued += DEPTH;
        idle(DEPTH + 4);
        check("final_empty", 32'(host.rx_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive half of the host serial link; sits directly upstream of the host communication interface.
- Oversamples the serial rx line 16x, deframes start/data/parity/stop, and checks parity.
- Pushes received bytes into a first-word-fall-through FIFO.
- Presents the rx_data/rx_empty/rd_en/parity_err read interface that the host interface consumes.

Parameters:
- SYS_CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 38400: serial bit rate.
- DATA_BITS, 8: data bits per frame, LSB first.
- STOP_BITS, 1: stop bits per frame (1 or 2).
- PARITY_MODE, 1: 0 = none, 1 = odd, 2 = even.
- FIFO_ADDR_BITS, 3: FIFO depth = 2^FIFO_ADDR_BITS entries.

Ports:
- clk  in  1: system clock.
- rst  in  1: asynchronous, active-high reset.
- rx  in  1: serial input, idle high, asynchronous to clk.
- rd_en  in  1: pop the FIFO head this cycle.
- rx_data  out  DATA_BITS: FIFO head, valid while rx_empty=0.
- rx_empty  out  1: FIFO holds no bytes.
- rx_full  out  1: FIFO holds 2^FIFO_ADDR_BITS bytes.
- parity_err  out  1: one-cycle pulse, a received byte had bad parity.
- frame_err  out  1: one-cycle pulse, stop bit sampled low.
- overrun  out  1: one-cycle pulse, a byte was dropped because the FIFO was full.

Behaviour:
- Reset (async, on rst high): state IDLE, FIFO empty, both pointers 0, tick counter 0.
  - Outputs: rx_empty=1, rx_full=0, rx_data=0, all error pulses 0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame discards the partial byte.
- Synchronisation: rx passes through a 2-FF synchroniser; all decisions use the synchronised value.
- Tick generator:
  - DIV = SYS_CLK_FREQ/(BAUD_RATE*16), integer floor, minimum 1.
  - A counter counts 0..DIV-1 and emits a 1-cycle tick at DIV-1, then wraps.
  - The counter free-runs, and restarts at 0 on entry to START.
- FSM, all state advances occur on ticks only:
  - IDLE: synchronised rx=0 moves to START, clearing the tick counter and the sample counter.
  - START: after 8 ticks (mid-bit), sample rx.
    - rx=1 is a glitch: return to IDLE, no error.
    - rx=0: go to DATA with bit index 0.
  - DATA: every 16 ticks sample rx into a shift register, LSB first. After bit DATA_BITS-1, go to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: after 16 ticks, sample the parity bit.
    - Odd mode: error if (XOR of data ^ parity bit) = 0.
    - Even mode: error if that XOR = 1.
  - STOP: every 16 ticks sample a stop bit, STOP_BITS times.
    - All stop bits high: commit the byte and return to IDLE.
    - Any stop bit low: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait until synchronised rx=1, then go to IDLE.
- Commit:
  - The byte is written into the FIFO on the cycle after the final stop-bit sample.
  - rx_empty falls one cycle later.
  - A parity-error byte is still written, and parity_err pulses in the commit cycle.
- FIFO:
  - Pointers are FIFO_ADDR_BITS+1 bits wide. Empty when the pointers are equal; full when the addresses are equal and the MSBs differ.
  - rx_data = mem[rd_ptr] combinationally (first-word fall-through).
  - rd_en while empty is ignored, and the pointer does not move.
  - Commit while full with rd_en=0: byte dropped, overrun pulses, FIFO unchanged.
  - Commit while full with rd_en=1: pop and push in the same cycle, no overrun, count unchanged.
  - Simultaneous commit and rd_en while non-empty: both occur, count unchanged.
  - Pointers wrap modulo 2^(FIFO_ADDR_BITS+1).
- The receiver is never stalled by FIFO state; receive and read sides are independent.

Test Plan (sim parameters SYS_CLK_FREQ=1600, BAUD_RATE=100, so DIV=1 and one bit = 16 clk):
- Reset: assert rst mid-cycle, rx held high → outputs reset immediately (asynchronously); rx_empty=1, rx_full=0, no pulses.
- Single byte 0xA5, odd parity bit=1, one stop bit → rx_empty falls within 2 clk of the stop mid-sample; rx_data=0xA5; rd_en for 1 cycle gives rx_empty=1; no error pulses.
- Byte 0x3C with parity bit=0 (wrong for odd) → 0x3C enters the FIFO; parity_err high for exactly 1 cycle at commit.
- rx low for 4 clk then high (glitch) → state returns to IDLE; no byte, no error. Then byte 0x00 with stop bit low → frame_err pulses once; FIFO stays empty; next valid byte 0x11 is received only after rx returns high.
- Send 9 bytes 0x01..0x09 with no reads → rx_full=1 after the 8th; overrun pulses on the 9th. Reading 8 times yields 0x01..0x08 in order, then rx_empty=1.
- FIFO full with rd_en asserted on the commit cycle of byte 0x55 → no overrun; rx_full stays 1; last entry read is 0x55.
